// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   key_state_e   - press-tracking FSM states.
//   scan_result_t - one full-scan result: valid bit plus hex code (code is 0 when not valid).
//   KeyMap        - hex code for each key, indexed by {row, col}.
//   decode_scan   - turns a 16-bit pressed snapshot (bit 4*col+row) into a scan result.
package keypad_pkg;

    typedef enum logic {
        StIdle,
        StPressed
    } key_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } scan_result_t;

    // Entry {r,c}; listed from index 15 (r3,c3) down to index 0 (r0,c0).
    localparam logic [15:0][3:0] KeyMap = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Exactly one pressed bit gives a key; zero or several (possible ghosting) give NONE.
    function automatic scan_result_t decode_scan(input logic [15:0] snap);
        scan_result_t res;
        logic [4:0]   hits;
        logic [3:0]   idx;
        hits = '0;
        idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                hits = hits + 5'd1;
                idx  = 4'(i);
            end
        end
        res.valid = (hits == 5'd1);
        // Snapshot bit index is {col,row}; the map is indexed by {row,col}.
        res.code  = res.valid ? KeyMap[{idx[1:0], idx[3:2]}] : 4'h0;
        return res;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a scan result only after DEBOUNCE_SCANS identical scans in a row.
//   clk, reset     - system clock, synchronous active-high reset.
//   scan_strobe    - one-cycle pulse at end of each full scan.
//   scan_result    - result of the scan completing on this edge.
//   stable_result  - the scan result, meaningful when stable_strobe is high.
//   stable_strobe  - high on an end-of-scan edge whose result has been seen
//                    DEBOUNCE_SCANS times consecutively (including this one).
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         scan_strobe,
    input  scan_result_t scan_result,
    output scan_result_t stable_result,
    output logic         stable_strobe
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_SCANS);

    scan_result_t    prev_q;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (scan_result == prev_q) begin
            if (count_q != CntMax) begin
                count_d = count_q + CntW'(1);
            end
        end else begin
            count_d = CntW'(1);
        end
    end

    // Stability is judged on the count this edge produces, so acceptance is same-edge.
    assign stable_strobe = scan_strobe && (count_d == CntMax);
    assign stable_result = scan_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= '0;
            count_q <= '0;
        end else if (scan_strobe) begin
            prev_q  <= scan_result;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned 4x4 keypad with debounce, ghost rejection and a one-entry
// event buffer with valid/ready handshake.
//   clk, reset  - system clock, synchronous active-high reset.
//   row         - keypad rows, active-low, asynchronous.
//   col         - keypad columns, active-low, one low at a time.
//   key_code    - hex code of the buffered event.
//   key_valid   - buffered event available.
//   key_ready   - consumer accepts the event on an edge where key_valid is also high.
//   key_held    - a debounced key is currently pressed.
//   overrun     - one-cycle pulse when a new event is dropped because the buffer is full.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 25000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int unsigned TickW = $clog2(SCAN_TICKS);
    localparam logic [TickW-1:0] TickLast = TickW'(SCAN_TICKS - 1);

    logic [3:0]       row_meta_q, row_sync_q;
    logic [TickW-1:0] tick_q;
    logic [1:0]       col_idx_q;
    logic [15:0]      snapshot_q, snapshot_d;
    key_state_e       state_q, state_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             tick_end, scan_end;
    scan_result_t     scan_result, stable_result;
    logic             stable_strobe;
    logic             key_event, handshake, load;

    assign tick_end = (tick_q == TickLast);
    assign scan_end = tick_end && (col_idx_q == 2'd3);

    // Snapshot including the sample taken this edge, so the c=3 column is part of the result.
    always_comb begin
        snapshot_d = snapshot_q;
        if (tick_end) begin
            snapshot_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
        end
    end

    assign scan_result = decode_scan(snapshot_d);

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .scan_strobe  (scan_end),
        .scan_result  (scan_result),
        .stable_result(stable_result),
        .stable_strobe(stable_strobe)
    );

    // A new press is reported only from IDLE; a different key while pressed waits for release.
    always_comb begin
        state_d   = state_q;
        key_event = 1'b0;
        case (state_q)
            StIdle: begin
                if (stable_strobe && stable_result.valid) begin
                    state_d   = StPressed;
                    key_event = 1'b1;
                end
            end
            StPressed: begin
                if (stable_strobe && !stable_result.valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign handshake = valid_q && key_ready;
    assign load      = key_event && (!valid_q || handshake);

    always_comb begin
        valid_d   = valid_q;
        code_d    = code_q;
        overrun_d = key_event && !load;
        if (handshake) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            code_d  = stable_result.code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            tick_q     <= '0;
            col_idx_q  <= 2'd0;
            snapshot_q <= '0;
            state_q    <= StIdle;
            code_q     <= 4'h0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            tick_q     <= tick_end ? '0 : tick_q + TickW'(1);
            if (tick_end) begin
                col_idx_q <= col_idx_q + 2'd1;
            end
            snapshot_q <= snapshot_d;
            state_q    <= state_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = (state_q == StPressed);
    assign overrun   = overrun_q;

endmodule
